// File: rtl/xge_mac_pkg.sv
// Shared 10GE MAC definitions: rx FIFO status bit positions and rx dequeue FSM states.
package xge_mac_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned STATUS_W = 8;
    localparam int unsigned MOD_W    = 3;

    localparam int unsigned RXSTATUS_SOP    = 7;
    localparam int unsigned RXSTATUS_EOP    = 6;
    localparam int unsigned RXSTATUS_ERR    = 5;
    localparam int unsigned RXSTATUS_MOD_HI = 2;
    localparam int unsigned RXSTATUS_MOD_LO = 0;
    localparam logic [STATUS_W-1:0] RXSTATUS_NONE = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } rx_deq_state_t;

endpackage

// File: rtl/rx_deq_stats.sv
// Packet and errored-packet counters fed by the presented eop/err flags; wrap modulo 2^STAT_W.
module rx_deq_stats #(
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              eop,
    input  logic              err,
    output logic [STAT_W-1:0] stat_rx_pkts,
    output logic [STAT_W-1:0] stat_rx_err_pkts
);

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            stat_rx_pkts     <= '0;
            stat_rx_err_pkts <= '0;
        end else begin
            if (eop) begin
                stat_rx_pkts <= stat_rx_pkts + STAT_W'(1);
            end
            if (eop && err) begin
                stat_rx_err_pkts <= stat_rx_err_pkts + STAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_dequeue.sv
// Receive FIFO reader for the 10GE user packet interface; framing and underflow status toggles.
// Define XGE_RX_DEQ_STATS_EN to add the stat_rx_pkts / stat_rx_err_pkts counters.
module rx_dequeue
    import xge_mac_pkg::*;
#(
    parameter int unsigned STAT_W = 32
) (
    input  logic                clk_156m25,
    input  logic                reset_156m25,
    input  logic [DATA_W-1:0]   rxdfifo_rdata,
    input  logic [STATUS_W-1:0] rxdfifo_rstatus,
    input  logic                rxdfifo_rempty,
    input  logic                rxdfifo_ralmost_empty,
    output logic                rxdfifo_ren,
    input  logic                pkt_rx_ren,
    output logic                pkt_rx_avail,
    output logic [DATA_W-1:0]   pkt_rx_data,
    output logic                pkt_rx_val,
    output logic                pkt_rx_sop,
    output logic                pkt_rx_eop,
    output logic                pkt_rx_err,
    output logic [MOD_W-1:0]    pkt_rx_mod,
    output logic                status_rxdfifo_udflow_tog,
`ifdef XGE_RX_DEQ_STATS_EN
    output logic                status_rx_framing_tog,
    output logic [STAT_W-1:0]   stat_rx_pkts,
    output logic [STAT_W-1:0]   stat_rx_err_pkts
`else
    output logic                status_rx_framing_tog
`endif
);

    rx_deq_state_t      state;
    rx_deq_state_t      state_nxt;
    logic               rd_pend;
    logic               present;
    logic               framing_err;
    logic               udflow;
    logic               udflow_q;
    logic               rd_sop;
    logic               rd_eop;
    logic               rd_err;
    logic [MOD_W-1:0]   rd_mod;
    logic [1:0]         unused_rstatus;

    assign rd_sop         = rxdfifo_rstatus[RXSTATUS_SOP];
    assign rd_eop         = rxdfifo_rstatus[RXSTATUS_EOP];
    assign rd_err         = rxdfifo_rstatus[RXSTATUS_ERR];
    assign rd_mod         = rxdfifo_rstatus[RXSTATUS_MOD_HI:RXSTATUS_MOD_LO];
    assign unused_rstatus = rxdfifo_rstatus[4:3];

    assign rxdfifo_ren = pkt_rx_ren && !rxdfifo_rempty && !reset_156m25;
    assign udflow      = pkt_rx_ren && rxdfifo_rempty && (state == PKT);

    // FSM state register
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Framing decision on the FIFO word arriving this cycle
    always_comb begin
        state_nxt   = state;
        present     = 1'b0;
        framing_err = 1'b0;
        if (rd_pend) begin
            unique case (state)
                IDLE: begin
                    if (rd_sop) begin
                        present = 1'b1;
                        if (!rd_eop) begin
                            state_nxt = PKT;
                        end
                    end else begin
                        framing_err = 1'b1;
                    end
                end
                PKT: begin
                    present = 1'b1;
                    // SOP inside a packet truncates the previous one and restarts framing
                    if (rd_sop) begin
                        framing_err = 1'b1;
                    end
                    if (rd_eop) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered user interface and status toggles
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            rd_pend                   <= 1'b0;
            pkt_rx_avail              <= 1'b0;
            pkt_rx_data               <= '0;
            pkt_rx_val                <= 1'b0;
            pkt_rx_sop                <= 1'b0;
            pkt_rx_eop                <= 1'b0;
            pkt_rx_err                <= 1'b0;
            pkt_rx_mod                <= '0;
            udflow_q                  <= 1'b0;
            status_rxdfifo_udflow_tog <= 1'b0;
            status_rx_framing_tog     <= 1'b0;
        end else begin
            rd_pend      <= rxdfifo_ren;
            pkt_rx_avail <= !rxdfifo_ralmost_empty;
            pkt_rx_val   <= present;
            pkt_rx_sop   <= present && rd_sop;
            pkt_rx_eop   <= present && rd_eop;
            pkt_rx_err   <= present && rd_eop && rd_err;
            if (present) begin
                pkt_rx_data <= rxdfifo_rdata;
                pkt_rx_mod  <= rd_eop ? rd_mod : '0;
            end
            udflow_q <= udflow;
            if (udflow && !udflow_q) begin
                status_rxdfifo_udflow_tog <= !status_rxdfifo_udflow_tog;
            end
            if (framing_err) begin
                status_rx_framing_tog <= !status_rx_framing_tog;
            end
        end
    end

`ifdef XGE_RX_DEQ_STATS_EN
    rx_deq_stats #(
        .STAT_W (STAT_W)
    ) u_stats (
        .clk_156m25       (clk_156m25),
        .reset_156m25     (reset_156m25),
        .eop              (pkt_rx_eop),
        .err              (pkt_rx_err),
        .stat_rx_pkts     (stat_rx_pkts),
        .stat_rx_err_pkts (stat_rx_err_pkts)
    );
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_rx_dequeue.sv
// Directed bench for rx_dequeue: a queue-backed FIFO model feeds the DUT, presented words are logged.
module tb_rx_dequeue;

    localparam int unsigned STAT_W = 4;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25;
    logic [63:0] rxdfifo_rdata;
    logic [7:0]  rxdfifo_rstatus;
    logic        rxdfifo_rempty;
    logic        rxdfifo_ralmost_empty;
    logic        rxdfifo_ren;
    logic        pkt_rx_ren;
    logic        pkt_rx_avail;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [2:0]  pkt_rx_mod;
    logic        status_rxdfifo_udflow_tog;
    logic        status_rx_framing_tog;
`ifdef XGE_RX_DEQ_STATS_EN
    logic [STAT_W-1:0] stat_rx_pkts;
    logic [STAT_W-1:0] stat_rx_err_pkts;
`endif

    always #3 clk_156m25 = ~clk_156m25;

    rx_dequeue #(
        .STAT_W (STAT_W)
    ) dut (
        .clk_156m25                (clk_156m25),
        .reset_156m25              (reset_156m25),
        .rxdfifo_rdata             (rxdfifo_rdata),
        .rxdfifo_rstatus           (rxdfifo_rstatus),
        .rxdfifo_rempty            (rxdfifo_rempty),
        .rxdfifo_ralmost_empty     (rxdfifo_ralmost_empty),
        .rxdfifo_ren               (rxdfifo_ren),
        .pkt_rx_ren                (pkt_rx_ren),
        .pkt_rx_avail              (pkt_rx_avail),
        .pkt_rx_data               (pkt_rx_data),
        .pkt_rx_val                (pkt_rx_val),
        .pkt_rx_sop                (pkt_rx_sop),
        .pkt_rx_eop                (pkt_rx_eop),
        .pkt_rx_err                (pkt_rx_err),
        .pkt_rx_mod                (pkt_rx_mod),
        .status_rxdfifo_udflow_tog (status_rxdfifo_udflow_tog),
`ifdef XGE_RX_DEQ_STATS_EN
        .status_rx_framing_tog     (status_rx_framing_tog),
        .stat_rx_pkts              (stat_rx_pkts),
        .stat_rx_err_pkts          (stat_rx_err_pkts)
`else
        .status_rx_framing_tog     (status_rx_framing_tog)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
    } obs_t;

    logic [71:0] fifo_q[$];
    obs_t        got[$];
    int          val_cyc[$];
    int          checks;
    int          failures;
    int          cyc;
    int          ren_cnt;
    int          first_ren;
    int          udf_chg;
    int          frm_chg;
    int          idle_bad;
    logic        prev_udf;
    logic        prev_frm;

    task automatic clear_log();
        got.delete();
        val_cyc.delete();
        ren_cnt   = 0;
        first_ren = -1;
        udf_chg   = 0;
        frm_chg   = 0;
        idle_bad  = 0;
        prev_udf  = status_rxdfifo_udflow_tog;
        prev_frm  = status_rx_framing_tog;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] s);
        fifo_q.push_back({d, s});
        rxdfifo_rempty = 1'b0;
    endtask

    // One clock: FIFO model pops on a sampled ren, then the DUT outputs of the new cycle are logged
    task automatic tick();
        logic        r;
        logic [71:0] w;
        obs_t        o;
        #1;
        r = rxdfifo_ren;
        if (r) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
        end
        @(posedge clk_156m25);
        #1;
        cyc++;
        if (r && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            rxdfifo_rdata   = w[71:8];
            rxdfifo_rstatus = w[7:0];
        end
        rxdfifo_rempty = (fifo_q.size() == 0);
        if (pkt_rx_val) begin
            o.d = pkt_rx_data; o.sop = pkt_rx_sop; o.eop = pkt_rx_eop;
            o.err = pkt_rx_err; o.mod = pkt_rx_mod;
            got.push_back(o);
            val_cyc.push_back(cyc);
        end else if (pkt_rx_sop || pkt_rx_eop || pkt_rx_err) begin
            idle_bad++;
        end
        if (status_rxdfifo_udflow_tog !== prev_udf) udf_chg++;
        if (status_rx_framing_tog !== prev_frm) frm_chg++;
        prev_udf = status_rxdfifo_udflow_tog;
        prev_frm = status_rx_framing_tog;
    endtask

    task automatic test_reset();
        reset_156m25   = 1'b1;
        pkt_rx_ren     = 1'b1;
        rxdfifo_rempty = 1'b0;
        #1;
        checks++;
        if (rxdfifo_ren !== 1'b0) begin
            failures++; $display("FAIL reset_ren: got %b expected 0", rxdfifo_ren);
        end
        tick(); tick();
        checks++;
        if ({pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_avail} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 00000",
                {pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_avail});
        end
        checks++;
        if ({pkt_rx_data, pkt_rx_mod, status_rxdfifo_udflow_tog, status_rx_framing_tog} !== 69'h0) begin
            failures++; $display("FAIL reset_data: got %h/%h/%b/%b expected 0", pkt_rx_data,
                pkt_rx_mod, status_rxdfifo_udflow_tog, status_rx_framing_tog);
        end
`ifdef XGE_RX_DEQ_STATS_EN
        checks++;
        if ({stat_rx_pkts, stat_rx_err_pkts} !== 8'h00) begin
            failures++; $display("FAIL reset_stats: got %h/%h expected 0/0", stat_rx_pkts, stat_rx_err_pkts);
        end
`endif
        pkt_rx_ren   = 1'b0;
        reset_156m25 = 1'b0;
        tick();
        checks++;
        if (pkt_rx_val !== 1'b0) begin
            failures++; $display("FAIL reset_idle_val: got %b expected 0", pkt_rx_val);
        end
    endtask

    task automatic test_avail();
        rxdfifo_ralmost_empty = 1'b0;
        tick();
        checks++;
        if (pkt_rx_avail !== 1'b1) begin
            failures++; $display("FAIL avail_set: got %b expected 1", pkt_rx_avail);
        end
        rxdfifo_ralmost_empty = 1'b1;
        tick();
        checks++;
        if (pkt_rx_avail !== 1'b0) begin
            failures++; $display("FAIL avail_clr: got %b expected 0", pkt_rx_avail);
        end
    endtask

    task automatic test_three_word();
        clear_log();
        push(64'hD0D0_0000_1111_2222, 8'h80);
        push(64'hD1D1_3333_4444_5555, 8'h00);
        push(64'hD2D2_6666_7777_8888, 8'h43);
        pkt_rx_ren = 1'b1;
        repeat (3) tick();
        pkt_rx_ren = 1'b0;
        repeat (4) tick();
        checks++;
        if (ren_cnt !== 3) begin
            failures++; $display("FAIL three_ren_cnt: got %0d expected 3", ren_cnt);
        end
        checks++;
        if (got.size() !== 3) begin
            failures++; $display("FAIL three_val_cnt: got %0d expected 3", got.size());
        end else begin
            checks++;
            if (val_cyc[0] - first_ren !== 2) begin
                failures++; $display("FAIL three_latency: got %0d expected 2", val_cyc[0] - first_ren);
            end
            checks++;
            if (val_cyc[2] - val_cyc[0] !== 2) begin
                failures++; $display("FAIL three_contig: got %0d expected 2", val_cyc[2] - val_cyc[0]);
            end
            checks++;
            if (got[0] !== {64'hD0D0_0000_1111_2222, 1'b1, 1'b0, 1'b0, 3'd0}) begin
                failures++; $display("FAIL three_w0: got %h expected sop word D0", got[0]);
            end
            checks++;
            if (got[1] !== {64'hD1D1_3333_4444_5555, 1'b0, 1'b0, 1'b0, 3'd0}) begin
                failures++; $display("FAIL three_w1: got %h expected mid word D1", got[1]);
            end
            checks++;
            if (got[2] !== {64'hD2D2_6666_7777_8888, 1'b0, 1'b1, 1'b0, 3'd3}) begin
                failures++; $display("FAIL three_w2: got %h expected eop word D2 mod 3", got[2]);
            end
        end
        checks++;
        if ({pkt_rx_data, pkt_rx_mod} !== {64'hD2D2_6666_7777_8888, 3'd3}) begin
            failures++; $display("FAIL three_hold: got %h/%0d expected D2 word/3", pkt_rx_data, pkt_rx_mod);
        end
        checks++;
        if (idle_bad + udf_chg + frm_chg !== 0) begin
            failures++; $display("FAIL three_quiet: got %0d/%0d/%0d expected 0/0/0", idle_bad, udf_chg, frm_chg);
        end
    endtask

    task automatic test_single();
        clear_log();
        push(64'h5151_5151_5151_5151, 8'hE0);
        push(64'h5252_5252_5252_5252, 8'hC5);
        pkt_rx_ren = 1'b1;
        repeat (2) tick();
        pkt_rx_ren = 1'b0;
        repeat (4) tick();
        checks++;
        if (got.size() !== 2) begin
            failures++; $display("FAIL single_cnt: got %0d expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== {64'h5151_5151_5151_5151, 1'b1, 1'b1, 1'b1, 3'd0}) begin
                failures++; $display("FAIL single_err_word: got %h expected sop/eop/err mod 0", got[0]);
            end
            checks++;
            if (got[1] !== {64'h5252_5252_5252_5252, 1'b1, 1'b1, 1'b0, 3'd5}) begin
                failures++; $display("FAIL single_good_word: got %h expected sop/eop mod 5", got[1]);
            end
        end
        checks++;
        if (frm_chg !== 0) begin
            failures++; $display("FAIL single_idle: got %0d framing toggles expected 0", frm_chg);
        end
    endtask

    task automatic test_underflow();
        clear_log();
        push(64'hA0A0_A0A0_A0A0_A0A0, 8'h80);
        push(64'hA1A1_A1A1_A1A1_A1A1, 8'h00);
        pkt_rx_ren = 1'b1;
        repeat (5) tick();
        pkt_rx_ren = 1'b0;
        repeat (3) tick();
        checks++;
        if (udf_chg !== 1) begin
            failures++; $display("FAIL udflow_once: got %0d toggles expected 1", udf_chg);
        end
        checks++;
        if (ren_cnt !== 2) begin
            failures++; $display("FAIL udflow_no_read: got %0d reads expected 2", ren_cnt);
        end
        push(64'hA2A2_A2A2_A2A2_A2A2, 8'h00);
        push(64'hA3A3_A3A3_A3A3_A3A3, 8'h45);
        pkt_rx_ren = 1'b1;
        repeat (2) tick();
        pkt_rx_ren = 1'b0;
        repeat (4) tick();
        checks++;
        if (got.size() !== 4) begin
            failures++; $display("FAIL udflow_words: got %0d expected 4", got.size());
        end else begin
            checks++;
            if (got[2] !== {64'hA2A2_A2A2_A2A2_A2A2, 1'b0, 1'b0, 1'b0, 3'd0}) begin
                failures++; $display("FAIL udflow_w2: got %h expected mid word A2", got[2]);
            end
            checks++;
            if (got[3] !== {64'hA3A3_A3A3_A3A3_A3A3, 1'b0, 1'b1, 1'b0, 3'd5}) begin
                failures++; $display("FAIL udflow_w3: got %h expected eop word A3 mod 5", got[3]);
            end
        end
        checks++;
        if ({udf_chg, frm_chg} !== {32'd1, 32'd0}) begin
            failures++; $display("FAIL udflow_after: got %0d/%0d expected 1/0", udf_chg, frm_chg);
        end
    endtask

    task automatic test_framing();
        clear_log();
        push(64'hF0F0_F0F0_F0F0_F0F0, 8'h00);
        push(64'hF1F1_F1F1_F1F1_F1F1, 8'h80);
        push(64'hF2F2_F2F2_F2F2_F2F2, 8'h80);
        push(64'hF3F3_F3F3_F3F3_F3F3, 8'h40);
        pkt_rx_ren = 1'b1;
        repeat (4) tick();
        pkt_rx_ren = 1'b0;
        repeat (4) tick();
        checks++;
        if (got.size() !== 3) begin
            failures++; $display("FAIL framing_cnt: got %0d expected 3", got.size());
        end else begin
            checks++;
            if (got[0] !== {64'hF1F1_F1F1_F1F1_F1F1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
                failures++; $display("FAIL framing_first: got %h expected sop word F1", got[0]);
            end
            checks++;
            if (got[1] !== {64'hF2F2_F2F2_F2F2_F2F2, 1'b1, 1'b0, 1'b0, 3'd0}) begin
                failures++; $display("FAIL framing_restart: got %h expected sop word F2", got[1]);
            end
            checks++;
            if (got[2] !== {64'hF3F3_F3F3_F3F3_F3F3, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                failures++; $display("FAIL framing_eop: got %h expected eop word F3", got[2]);
            end
        end
        checks++;
        if (frm_chg !== 2) begin
            failures++; $display("FAIL framing_tog: got %0d toggles expected 2", frm_chg);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        push(64'hB0, 8'h80);
        push(64'hB1, 8'h40);
        push(64'hB2, 8'hC1);
        push(64'hB3, 8'h80);
        push(64'hB4, 8'h00);
        push(64'hB5, 8'h67);
        pkt_rx_ren = 1'b1;
        repeat (6) tick();
        pkt_rx_ren = 1'b0;
        repeat (4) tick();
        checks++;
        if (ren_cnt !== 6) begin
            failures++; $display("FAIL b2b_ren: got %0d expected 6", ren_cnt);
        end
        checks++;
        if (got.size() !== 6) begin
            failures++; $display("FAIL b2b_cnt: got %0d expected 6", got.size());
        end else begin
            checks++;
            if (val_cyc[5] - val_cyc[0] !== 5) begin
                failures++; $display("FAIL b2b_bubbles: got span %0d expected 5", val_cyc[5] - val_cyc[0]);
            end
            checks++;
            if (got[2] !== {64'hB2, 1'b1, 1'b1, 1'b0, 3'd1}) begin
                failures++; $display("FAIL b2b_single: got %h expected sop/eop mod 1", got[2]);
            end
            checks++;
            if (got[5] !== {64'hB5, 1'b0, 1'b1, 1'b1, 3'd7}) begin
                failures++; $display("FAIL b2b_last: got %h expected eop/err mod 7", got[5]);
            end
        end
        checks++;
        if (frm_chg !== 0) begin
            failures++; $display("FAIL b2b_framing: got %0d expected 0", frm_chg);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        push(64'hC0, 8'h80);
        push(64'hC1, 8'h00);
        push(64'hC2, 8'h40);
        pkt_rx_ren = 1'b1;
        repeat (2) tick();
        reset_156m25 = 1'b1;
        #1;
        checks++;
        if (rxdfifo_ren !== 1'b0) begin
            failures++; $display("FAIL rstmid_ren: got %b expected 0", rxdfifo_ren);
        end
        tick();
        checks++;
        if ({pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod, pkt_rx_data,
             status_rxdfifo_udflow_tog, status_rx_framing_tog} !== 73'h0) begin
            failures++; $display("FAIL rstmid_outputs: got %b/%h expected all 0",
                {pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod}, pkt_rx_data);
        end
        got.delete();
        reset_156m25 = 1'b0;
        tick();
        pkt_rx_ren = 1'b0;
        repeat (3) tick();
        checks++;
        if (got.size() !== 0) begin
            failures++; $display("FAIL rstmid_drop: got %0d words expected 0", got.size());
        end
        checks++;
        if (status_rx_framing_tog !== 1'b1) begin
            failures++; $display("FAIL rstmid_framing: got %b expected 1", status_rx_framing_tog);
        end
    endtask

`ifdef XGE_RX_DEQ_STATS_EN
    task automatic test_stats();
        reset_156m25 = 1'b1;
        tick();
        reset_156m25 = 1'b0;
        clear_log();
        for (int i = 0; i < 19; i++) begin
            push(64'(i), (i == 5 || i == 12) ? 8'hE2 : 8'hC0);
        end
        pkt_rx_ren = 1'b1;
        repeat (19) tick();
        pkt_rx_ren = 1'b0;
        repeat (5) tick();
        checks++;
        if (got.size() !== 19) begin
            failures++; $display("FAIL stats_words: got %0d expected 19", got.size());
        end
        checks++;
        if (stat_rx_pkts !== 4'd3) begin
            failures++; $display("FAIL stats_pkts: got %0d expected 3", stat_rx_pkts);
        end
        checks++;
        if (stat_rx_err_pkts !== 4'd2) begin
            failures++; $display("FAIL stats_err_pkts: got %0d expected 2", stat_rx_err_pkts);
        end
    endtask
`endif

    initial begin
        checks                = 0;
        failures              = 0;
        cyc                   = 0;
        reset_156m25          = 1'b1;
        pkt_rx_ren            = 1'b0;
        rxdfifo_rempty        = 1'b1;
        rxdfifo_ralmost_empty = 1'b1;
        rxdfifo_rdata         = '0;
        rxdfifo_rstatus       = '0;
        test_reset();
        test_avail();
        test_three_word();
        test_single();
        test_underflow();
        test_framing();
        test_back_to_back();
        test_reset_mid();
`ifdef XGE_RX_DEQ_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
